scan_req_bridge: RTL and testbench
==================================

SCAN_REQ_BRIDGE -- requirements
Module: scan_req_bridge

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops synchronising scan_id into clk.
REQ-002 Parameter: TIMEOUT, default 255, max clk cycles waited for req_ready or resp_valid.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 scan_id  in  1  command strobe from the scan pins; asynchronous to clk; each toggle (either edge) is one command.
REQ-006 cfg_wen, cfg_ren  in  1 each  command type from the scan chip latches; static while the bridge is busy.
REQ-007 cfg_addr  in  20  command address; cfg_wdata  in  32  write data.
REQ-008 req_valid  out  1; req_ready  in  1; req_we  out  1; req_addr  out  20; req_wdata  out  32  bus request channel.
REQ-009 req_grp  out  1 (= req_addr[18], group A=0 / B=1); req_ctrl  out  1 (= req_addr[11], control register =1 / SRAM =0).
REQ-010 resp_valid  in  1; resp_rdata  in  32  read response channel; resp_valid is ignored outside WAIT_RESP.
REQ-011 rdata  out  32; ready  out  1; err  out  1  status captured by the scan chain on load_chain.

Function
REQ-012 scan_id passes through a SYNC_STAGES flop chain plus one history flop; cmd_evt = synced XOR history.
REQ-013 Latency: scan_id toggle to req_valid high = SYNC_STAGES+1 clk cycles when IDLE.
REQ-014 FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
REQ-015 IDLE with cmd_evt: register cfg_* into req_*, clear ready and err; cfg_wen=1 -> ISSUE with req_we=1 (wen wins if both set); cfg_ren=1 only -> ISSUE with req_we=0; neither -> DONE, no bus request.
REQ-016 ISSUE: req_valid=1, req_* stable until the req_valid&&req_ready handshake; write -> DONE; read -> WAIT_RESP.
REQ-017 WAIT_RESP: on resp_valid, rdata <= resp_rdata, go DONE; resp_valid in the same cycle as the read handshake is not accepted.
REQ-018 DONE lasts one cycle: ready <= 1, go IDLE; ready then holds until the next accepted command.
REQ-019 rdata is updated only by a read response or a timeout; writes and no-ops leave it unchanged.
REQ-020 Timeout counter (8 bit, saturating) clears on entry to ISSUE and WAIT_RESP and increments each cycle spent there; when it reaches TIMEOUT: drop req_valid, err <= 1, rdata <= 32'hDEAD_BEEF on reads, go DONE.
REQ-021 cmd_evt while not IDLE sets a one-deep pending flag; further events while it is set are dropped. In IDLE, a set pending flag acts as cmd_evt, is cleared, and uses the current cfg_* values.
REQ-022 req_valid is never asserted in IDLE, WAIT_RESP or DONE.

Reset
REQ-023 On rst_n low: state IDLE; req_valid 0; req_we 0; req_addr 0; req_wdata 0; rdata 0; ready 0; err 0; pending 0; timeout counter 0.
REQ-024 Sync chain and history flop reset to 0; a scan_id held at 1 through reset release produces exactly one cmd_evt.
REQ-025 Reset mid-transaction aborts immediately; no req_valid in the cycle after deassertion; the aborted command is not replayed.

Verification
REQ-026 Write: cfg_wen=1, cfg_addr=20'h00001, cfg_wdata=32'h87654321, toggle scan_id, req_ready=1 -> req_valid for 1 cycle with those values, req_grp=0, req_ctrl=0, ready=1, rdata unchanged.
REQ-027 Read of group B control register: cfg_ren=1, cfg_addr=20'h40800, resp_rdata=32'hF1F2F3FF 5 cycles after the handshake -> req_grp=1, req_ctrl=1, rdata=32'hF1F2F3FF, ready=1, err=0.
REQ-028 Backpressure: req_ready held low for 10 cycles, write 20'h40007/32'h12345678 -> req_* stable all 10 cycles, a single handshake, then ready=1.
REQ-029 Timeout: read 20'h00800 with resp_valid never asserted -> after TIMEOUT cycles in WAIT_RESP, err=1, rdata=32'hDEAD_BEEF, ready=1, bridge back in IDLE.
REQ-030 Overlap: two scan_id toggles during one WAIT_RESP -> exactly one additional command runs after DONE; a third toggle during the same wait is dropped.
REQ-031 Reset: rst_n asserted during ISSUE -> all outputs at REQ-023 values within the same cycle; no request issued after release.

Source files
------------

// File: rtl/scan_req_bridge.sv
// Bridges toggle-coded scan commands from an asynchronous scan_id pin onto a
// valid/ready bus request channel, capturing read data and status for the scan chain.
module scan_req_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_id,
  input  logic        cfg_wen,
  input  logic        cfg_ren,
  input  logic [19:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [19:0] req_addr,
  output logic [31:0] req_wdata,
  output logic        req_grp,
  output logic        req_ctrl,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   cmd_evt;
  logic                   pend_q;
  logic [7:0]             cnt_q;
  logic                   load_cmd;
  logic                   take_resp;
  logic                   timeout_hit;
  logic                   set_ready;
  logic                   cnt_clr;
  logic                   cnt_inc;

  // Every edge of scan_id is a command, so detect any change after synchronising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q[0] <= scan_id;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign cmd_evt = sync_q[SYNC_STAGES-1] ^ hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    load_cmd    = 1'b0;
    take_resp   = 1'b0;
    timeout_hit = 1'b0;
    set_ready   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_evt || pend_q) begin
          load_cmd = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = (cfg_wen || cfg_ren) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        cnt_inc = 1'b1;
        if (req_ready) begin
          cnt_clr = 1'b1;
          state_d = req_we ? DONE : WAIT_RESP;
        end else if (cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      WAIT_RESP: begin
        cnt_inc = 1'b1;
        if (resp_valid) begin
          take_resp = 1'b1;
          state_d   = DONE;
        end else if (cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        set_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A single command can wait behind the active one; in IDLE a queued one is
  // consumed first and a simultaneous fresh event takes its place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (pend_q) pend_q <= cmd_evt;
    end else if (cmd_evt) begin
      pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (cnt_inc && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (load_cmd) begin
        req_we    <= cfg_wen;
        req_addr  <= cfg_addr;
        req_wdata <= cfg_wdata;
        ready     <= 1'b0;
        err       <= 1'b0;
      end
      if (take_resp) rdata <= resp_rdata;
      if (timeout_hit) begin
        err <= 1'b1;
        if (!req_we) rdata <= 32'hDEAD_BEEF;
      end
      if (set_ready) ready <= 1'b1;
    end
  end

  assign req_valid = (state_q == ISSUE);
  assign req_grp   = req_addr[18];
  assign req_ctrl  = req_addr[11];

endmodule

// File: tb/tb_scan_req_bridge.sv
// Scoreboard bench for scan_req_bridge: expected requests and completions are
// queued by the stimulus and consumed by an independent monitor.
module tb_scan_req_bridge;

  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_id = 1'b1;
  logic        cfg_wen = 1'b0;
  logic        cfg_ren = 1'b0;
  logic [19:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic        req_we;
  logic [19:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_grp;
  logic        req_ctrl;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic        grp;
    logic        ctrl;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } done_t;

  req_t  req_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int hs_cycle = 0;
  int done_cycle = 0;

  logic        resp_enable = 1'b1;
  int          resp_delay  = 5;
  logic [31:0] resp_data   = '0;

  scan_req_bridge #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .scan_id(scan_id),
    .cfg_wen(cfg_wen), .cfg_ren(cfg_ren), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_grp(req_grp), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic toggleScan();
    @(posedge clk);
    #1 scan_id = ~scan_id;
  endtask

  task automatic applyStimulus(input logic we, input logic re,
                               input logic [19:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #1;
    cfg_wen   = we;
    cfg_ren   = re;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    scan_id   = ~scan_id;
  endtask

  task automatic expectReq(input logic we, input logic [19:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.grp = addr[18]; r.ctrl = addr[11];
    req_q.push_back(r);
  endtask

  task automatic expectDone(input logic [31:0] rd, input logic e);
    done_t d;
    d.rdata = rd; d.err = e;
    done_q.push_back(d);
  endtask

  task automatic waitReqValid(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (req_valid) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) flagFail("req_valid wait expired");
  endtask

  task automatic waitDone(input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      if (req_q.size() == 0 && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flagFail("completion wait expired");
  endtask

  task automatic checkResetValues();
    checkOutput("rst req_valid", {31'd0, req_valid}, 32'd0);
    checkOutput("rst req_we",    {31'd0, req_we},    32'd0);
    checkOutput("rst req_addr",  {12'd0, req_addr},  32'd0);
    checkOutput("rst req_wdata", req_wdata,          32'd0);
    checkOutput("rst rdata",     rdata,              32'd0);
    checkOutput("rst ready",     {31'd0, ready},     32'd0);
    checkOutput("rst err",       {31'd0, err},       32'd0);
  endtask

  // Monitor: request fields are checked every cycle req_valid is high so that
  // stalled requests are also held stable; completions are checked on ready's rise.
  initial begin
    logic  ready_prev = 1'b0;
    req_t  er;
    done_t ed;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ready_prev = 1'b0;
      end else begin
        if (req_valid) begin
          if (req_q.size() == 0) begin
            flagFail("unexpected req_valid");
          end else begin
            er = req_q[0];
            checkOutput("req_we",    {31'd0, req_we},   {31'd0, er.we});
            checkOutput("req_addr",  {12'd0, req_addr}, {12'd0, er.addr});
            checkOutput("req_wdata", req_wdata,         er.wdata);
            checkOutput("req_grp",   {31'd0, req_grp},  {31'd0, er.grp});
            checkOutput("req_ctrl",  {31'd0, req_ctrl}, {31'd0, er.ctrl});
            if (req_ready) begin
              void'(req_q.pop_front());
              hs_cycle = cycle;
            end
          end
        end
        if (ready && !ready_prev) begin
          if (done_q.size() == 0) begin
            flagFail("unexpected ready");
          end else begin
            ed = done_q.pop_front();
            checkOutput("rdata", rdata,          ed.rdata);
            checkOutput("err",   {31'd0, err},   {31'd0, ed.err});
            done_cycle = cycle;
          end
        end
        ready_prev = ready;
      end
    end
  end

  // Responder: answers each read handshake after resp_delay cycles.
  initial forever begin
    @(negedge clk);
    if (rst_n && req_valid && req_ready && !req_we && resp_enable) begin
      repeat (resp_delay) @(posedge clk);
      #1;
      resp_valid = 1'b1;
      resp_rdata = resp_data;
      @(posedge clk);
      #1;
      resp_valid = 1'b0;
      resp_rdata = '0;
    end
  end

  initial begin
    int lat;
    int dur;

    // Reset with scan_id held high: exactly one no-op command after release.
    expectDone(32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1 checkResetValues();
    rst_n = 1'b1;
    waitDone(40);
    repeat (20) @(posedge clk);

    // Write with immediate ready, plus sync latency.
    req_ready = 1'b1;
    expectReq(1'b1, 20'h00001, 32'h8765_4321);
    expectDone(32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h00001, 32'h8765_4321);
    waitReqValid(20, lat);
    checkOutput("toggle to req_valid latency", lat, SYNC_STAGES + 1);
    waitDone(40);

    // Read of a group B control register.
    resp_delay = 5;
    resp_data  = 32'hF1F2_F3FF;
    expectReq(1'b0, 20'h40800, 32'd0);
    expectDone(32'hF1F2_F3FF, 1'b0);
    applyStimulus(1'b0, 1'b1, 20'h40800, 32'd0);
    waitDone(60);

    // Backpressure on a write; rdata keeps the last read value.
    req_ready = 1'b0;
    expectReq(1'b1, 20'h40007, 32'h1234_5678);
    expectDone(32'hF1F2_F3FF, 1'b0);
    applyStimulus(1'b1, 1'b0, 20'h40007, 32'h1234_5678);
    waitReqValid(20, lat);
    repeat (10) @(posedge clk);
    #1 req_ready = 1'b1;
    waitDone(40);

    // Read that never gets a response.
    resp_enable = 1'b0;
    expectReq(1'b0, 20'h00800, 32'd0);
    expectDone(32'hDEAD_BEEF, 1'b1);
    applyStimulus(1'b0, 1'b1, 20'h00800, 32'd0);
    waitDone(TIMEOUT + 60);
    dur = done_cycle - hs_cycle;
    n_checks++;
    if (dur < TIMEOUT || dur > TIMEOUT + 4) begin
      n_fail++;
      $display("[TB] FAIL timeout duration: got %0d cycles, expected %0d..%0d",
               dur, TIMEOUT, TIMEOUT + 4);
    end
    resp_enable = 1'b1;

    // Three toggles during one response wait yield exactly one extra read.
    resp_delay = 20;
    resp_data  = 32'hA5A5_0001;
    expectReq(1'b0, 20'h00004, 32'd0);
    expectReq(1'b0, 20'h00004, 32'd0);
    expectDone(32'hA5A5_0001, 1'b0);
    expectDone(32'hA5A5_0001, 1'b0);
    applyStimulus(1'b0, 1'b1, 20'h00004, 32'd0);
    waitReqValid(20, lat);
    repeat (3) begin
      repeat (3) @(posedge clk);
      toggleScan();
    end
    waitDone(150);
    repeat (30) @(posedge clk);

    // Reset while a write is stalled in the issue state; scan_id ends low.
    req_ready = 1'b0;
    expectReq(1'b1, 20'h00010, 32'hCAFE_0010);
    applyStimulus(1'b1, 1'b0, 20'h00010, 32'hCAFE_0010);
    waitReqValid(20, lat);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkResetValues();
    req_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_ready = 1'b1;
    @(posedge clk);
    #1 checkOutput("req_valid after release", {31'd0, req_valid}, 32'd0);
    repeat (20) @(posedge clk);
    checkOutput("ready after abort", {31'd0, ready}, 32'd0);

    checkOutput("req queue drained",  req_q.size(),  32'd0);
    checkOutput("done queue drained", done_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
